// File: rtl/flash_uart_dump.sv
// flash_uart_dump: reads a flash region in bursts into a byte FIFO and streams it to a UART,
// either as raw bytes or as uppercase hex text split into CR/LF-terminated lines.
module flash_uart_dump #(
    parameter logic [23:0] START_ADDR = 24'h100000,
    parameter int NUM_BYTES = 256,
    parameter int BURST = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int HEX_MODE = 0,
    parameter int LINE_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [23:0] spi_addr,
    output logic [15:0] spi_len,
    output logic        spi_go,
    input  logic        spi_rdy,
    input  logic [7:0]  spi_data,
    input  logic        spi_valid,
    output logic [7:0]  uart_data,
    output logic        uart_start,
    input  logic        uart_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, WAIT_ROOM, ISSUE, RECEIVE, DRAIN} state_t;
    state_t state;
    logic [23:0] addr;
    logic [24:0] remaining, out_left, burst_left, chunk;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [31:0] room, line_cnt;
    logic [1:0] ph;
    logic [7:0] head, chr;
    logic wr, pop, avail, fire, line_end;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign count = wr_ptr - rd_ptr;
    assign room = 32'(FIFO_DEPTH) - 32'(count);
    assign chunk = remaining < 25'(BURST) ? remaining : 25'(BURST);
    assign head = mem[rd_ptr[AW-1:0]];
    // ph: 0 high nibble, 1 low nibble, 2 CR, 3 LF; the byte stays in the FIFO until its low nibble goes out
    assign avail = HEX_MODE != 0 ? (ph != 2'd0 || count != 0) : count != 0;
    assign chr = HEX_MODE == 0 ? head : ph == 2'd0 ? hex(head[7:4]) : ph == 2'd1 ? hex(head[3:0]) :
                 ph == 2'd2 ? 8'h0D : 8'h0A;
    assign fire = avail && uart_ready && !uart_start;
    assign pop = fire && (HEX_MODE == 0 || ph == 2'd1);
    assign wr = state == RECEIVE && spi_valid;
    assign line_end = line_cnt == 32'(LINE_BYTES - 1) || out_left == 25'd1;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr[AW-1:0]] <= spi_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            spi_go <= 1'b0;
            spi_addr <= '0;
            spi_len <= '0;
            uart_start <= 1'b0;
            uart_data <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ph <= 2'd0;
            line_cnt <= '0;
            addr <= '0;
            remaining <= '0;
            out_left <= '0;
            burst_left <= '0;
        end else begin
            done <= 1'b0;
            spi_go <= 1'b0;
            uart_start <= fire;
            if (fire) uart_data <= chr;
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                out_left <= out_left - 25'd1;
            end
            if (HEX_MODE != 0 && fire) begin
                ph <= ph == 2'd0 ? 2'd1 : ph == 2'd1 ? (line_end ? 2'd2 : 2'd0) : ph == 2'd2 ? 2'd3 : 2'd0;
                if (ph == 2'd1) line_cnt <= line_end ? '0 : line_cnt + 32'd1;
            end
            case (state)
                IDLE: if (start) begin
                    addr <= START_ADDR;
                    remaining <= 25'(NUM_BYTES);
                    out_left <= 25'(NUM_BYTES);
                    busy <= 1'b1;
                    state <= WAIT_ROOM;
                end
                WAIT_ROOM: if (room >= 32'(chunk) && spi_rdy) begin
                    spi_go <= 1'b1;
                    spi_addr <= addr;
                    spi_len <= 16'(chunk - 25'd1);
                    burst_left <= chunk;
                    state <= ISSUE;
                end
                ISSUE: state <= RECEIVE;
                RECEIVE: if (spi_valid) begin
                    addr <= addr + 24'd1;
                    remaining <= remaining - 25'd1;
                    burst_left <= burst_left - 25'd1;
                    if (burst_left == 25'd1) state <= remaining == 25'd1 ? DRAIN : WAIT_ROOM;
                end
                DRAIN: if (count == 0 && ph == 2'd0 && uart_ready && !uart_start) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_uart_dump.sv
// tb_flash_uart_dump: four differently configured dumpers, each with its own flash and UART model,
// exercised by directed scenarios with hand-computed expected characters.
module tb_flash_uart_dump;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, clr;
    logic [3:0] start, stall, busy, done, spi_go, spi_rdy, spi_valid, uart_start, uart_ready;
    logic [3:0][23:0] spi_addr;
    logic [3:0][15:0] spi_len;
    logic [3:0][7:0] spi_data, uart_data;
    int checks = 0, fails = 0;
    logic [7:0] exp_c [10] = '{8'h30, 8'h41, 8'h46, 8'h33, 8'h0D, 8'h0A, 8'h35, 8'h43, 8'h0D, 8'h0A};
    logic [7:0] exp_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    function automatic logic [7:0] fbyte(input int i, input logic [23:0] a);
        if (i == 0) return a[1:0] == 2'd0 ? 8'h11 : a[1:0] == 2'd1 ? 8'h22 : a[1:0] == 2'd2 ? 8'h33 : 8'h44;
        if (i == 2) return a[1:0] == 2'd0 ? 8'h0A : a[1:0] == 2'd1 ? 8'hF3 : 8'h5C;
        return a[7:0] + 8'h40;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        localparam logic [23:0] SA = g == 3 ? 24'hFFFFFE : 24'h100000;
        localparam int NB = g == 0 ? 4 : g == 1 ? 40 : g == 2 ? 3 : 4;
        localparam int BU = g == 3 ? 4 : 16;
        localparam int HX = g == 2 ? 1 : 0;
        localparam int LB = g == 2 ? 2 : 16;
        logic [23:0] f_addr = '0, first_addr = '0;
        logic [16:0] f_cnt = '0;
        logic [1:0] f_dly = '0, ub = '0;
        logic [15:0] last_len = '0;
        logic [7:0] cap [64];
        int ncap = 0, n_go = 0, n_done = 0;
        assign spi_valid[g] = f_cnt != 0 && f_dly == 0;
        assign spi_rdy[g] = f_cnt == 0;
        assign spi_data[g] = fbyte(g, f_addr);
        assign uart_ready[g] = ub == 0 && !stall[g];
        always @(posedge clk) begin
            if (spi_go[g]) begin
                f_addr <= spi_addr[g];
                f_cnt <= {1'b0, spi_len[g]} + 17'd1;
                f_dly <= 2'd2;
            end else if (f_cnt != 0) begin
                if (f_dly != 0) f_dly <= f_dly - 2'd1;
                else begin
                    f_addr <= f_addr + 24'd1;
                    f_cnt <= f_cnt - 17'd1;
                end
            end
            if (uart_start[g]) begin
                if (ncap < 64) cap[ncap] <= uart_data[g];
                ncap <= ncap + 1;
                ub <= 2'd3;
            end else if (ub != 0) ub <= ub - 2'd1;
            if (spi_go[g]) begin
                if (n_go == 0) first_addr <= spi_addr[g];
                last_len <= spi_len[g];
                n_go <= n_go + 1;
            end
            if (done[g]) n_done <= n_done + 1;
            if (clr) begin
                ncap <= 0;
                n_go <= 0;
                n_done <= 0;
            end
        end
        flash_uart_dump #(.START_ADDR(SA), .NUM_BYTES(NB), .BURST(BU), .FIFO_DEPTH(32),
                          .HEX_MODE(HX), .LINE_BYTES(LB)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .spi_addr(spi_addr[g]), .spi_len(spi_len[g]), .spi_go(spi_go[g]), .spi_rdy(spi_rdy[g]),
            .spi_data(spi_data[g]), .spi_valid(spi_valid[g]), .uart_data(uart_data[g]),
            .uart_start(uart_start[g]), .uart_ready(uart_ready[g]));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int i, input int lim, input string tag);
        int n = 0;
        while (!done[i] && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done[i]), 1);
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_busy"}, 32'(busy[1]), 0);
        chk({tag, "_done"}, 32'(done[1]), 0);
        chk({tag, "_go"}, 32'(spi_go[1]), 0);
        chk({tag, "_ustart"}, 32'(uart_start[1]), 0);
        chk({tag, "_addr"}, 32'(spi_addr[1]), 0);
        chk({tag, "_len"}, 32'(spi_len[1]), 0);
        chk({tag, "_udata"}, 32'(uart_data[1]), 0);
    endtask

    initial begin
        rst = 1'b0;
        clr = 1'b1;
        start = '0;
        stall = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_go", 32'(spi_go), 0);
        chk("rst_ustart", 32'(uart_start), 0);
        chk_reset1("rst1");
        rst = 1'b1;
        clr = 1'b0;
        @(negedge clk);

        pulse_start(0);
        chk("a_busy", 32'(busy[0]), 1);
        repeat (3) @(negedge clk);
        pulse_start(0);
        wait_done(0, 500, "a_done");
        repeat (60) @(negedge clk);
        chk("a_idle", 32'(busy[0]), 0);
        chk("a_go", 32'(u[0].n_go), 1);
        chk("a_len", 32'(u[0].last_len), 3);
        chk("a_addr", 32'(u[0].first_addr), 32'h100000);
        chk("a_ndone", 32'(u[0].n_done), 1);
        chk("a_nchar", 32'(u[0].ncap), 4);
        for (int k = 0; k < 4; k++) chk("a_char", 32'(u[0].cap[k]), 32'(exp_a[k]));

        pulse_clr();
        stall[1] = 1'b1;
        pulse_start(1);
        repeat (2000) @(negedge clk);
        chk("b_go_stall", 32'(u[1].n_go), 2);
        chk("b_nochar", 32'(u[1].ncap), 0);
        chk("b_busy", 32'(busy[1]), 1);
        stall[1] = 1'b0;
        wait_done(1, 3000, "b_done");
        chk("b_go", 32'(u[1].n_go), 3);
        chk("b_len", 32'(u[1].last_len), 7);
        chk("b_nchar", 32'(u[1].ncap), 40);
        for (int k = 0; k < 40; k++) chk("b_byte", 32'(u[1].cap[k]), 32'h40 + k);

        pulse_clr();
        pulse_start(2);
        wait_done(2, 1000, "c_done");
        repeat (5) @(negedge clk);
        chk("c_nchar", 32'(u[2].ncap), 10);
        for (int k = 0; k < 10; k++) chk("c_char", 32'(u[2].cap[k]), 32'(exp_c[k]));

        pulse_clr();
        pulse_start(3);
        wait_done(3, 500, "d_done");
        chk("d_addr", 32'(u[3].first_addr), 32'hFFFFFE);
        chk("d_go", 32'(u[3].n_go), 1);
        chk("d_len", 32'(u[3].last_len), 3);
        chk("d_nchar", 32'(u[3].ncap), 4);
        for (int k = 0; k < 4; k++) chk("d_byte", 32'(u[3].cap[k]), 32'h3E + k);

        pulse_clr();
        pulse_start(1);
        for (int n = 0; n < 500 && u[1].n_go < 2; n++) @(negedge clk);
        chk("e_second_go", 32'(u[1].n_go), 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset1("e_rst");
        rst = 1'b1;
        pulse_clr();
        repeat (40) @(negedge clk);
        chk("e_quiet_char", 32'(u[1].ncap), 0);
        chk("e_quiet_done", 32'(u[1].n_done), 0);
        pulse_start(1);
        wait_done(1, 2000, "e_done");
        repeat (60) @(negedge clk);
        chk("e_ndone", 32'(u[1].n_done), 1);
        chk("e_nchar", 32'(u[1].ncap), 40);
        for (int k = 0; k < 40; k++) chk("e_byte", 32'(u[1].cap[k]), 32'h40 + k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/flash_uart_dump.md
FLASH_UART_DUMP -- requirements
Module: flash_uart_dump

Interface
REQ-001 SHALL have parameter START_ADDR, default 24'h100000, first flash byte address.
REQ-002 SHALL have parameter NUM_BYTES, default 256, bytes per dump (1..2^24).
REQ-003 SHALL have parameter BURST, default 16, bytes per flash read command (1..FIFO_DEPTH).
REQ-004 SHALL have parameter FIFO_DEPTH, default 32, byte buffer depth (power of 2, >=2).
REQ-005 SHALL have parameter HEX_MODE, default 0; 0 = raw bytes, 1 = ASCII hex text.
REQ-006 SHALL have parameter LINE_BYTES, default 16, bytes per text line in HEX_MODE.
REQ-007 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-low reset.
REQ-008 SHALL have ports: start in 1 dump request pulse; busy out 1 dump in progress; done out 1 one-cycle completion pulse.
REQ-009 SHALL have flash command ports: spi_addr out 24; spi_len out 16 (bytes-1); spi_go out 1; spi_rdy in 1; spi_data in 8; spi_valid in 1.
REQ-010 SHALL have UART ports: uart_data out 8; uart_start out 1; uart_ready in 1.

Function
REQ-011 SHALL implement FSM IDLE -> WAIT_ROOM -> ISSUE -> RECEIVE -> (WAIT_ROOM | DRAIN) -> IDLE.
REQ-012 IDLE: start=1 SHALL load addr=START_ADDR, remaining=NUM_BYTES, assert busy next cycle; start SHALL be ignored while busy.
REQ-013 WAIT_ROOM: SHALL wait until free FIFO slots >= min(BURST, remaining) and spi_rdy=1, then go to ISSUE.
REQ-014 ISSUE: SHALL drive spi_go=1 for exactly one cycle with spi_addr=addr, spi_len=min(BURST,remaining)-1; spi_addr/spi_len SHALL stay stable until the next ISSUE.
REQ-015 RECEIVE: every spi_valid cycle SHALL write spi_data into FIFO, increment addr (24-bit wrap at 24'hFFFFFF->0) and decrement remaining.
REQ-016 On the last byte of a burst: remaining>0 -> WAIT_ROOM; remaining=0 -> DRAIN.
REQ-017 spi_valid outside RECEIVE SHALL be discarded; no FIFO write.
REQ-018 FIFO SHALL never overflow (guaranteed by REQ-013); read and write in the same cycle SHALL be permitted, including when full or empty.
REQ-019 UART side SHALL assert uart_start for one cycle when a character is available, uart_ready=1, and uart_start was 0 in the previous cycle; uart_data SHALL be valid in that cycle.
REQ-020 HEX_MODE=0: each FIFO byte SHALL be sent unchanged, one character per byte.
REQ-021 HEX_MODE=1: each byte SHALL be sent as two uppercase hex ASCII chars, high nibble first ('0'-'9' = 8'h30-8'h39, 'A'-'F' = 8'h41-8'h46).
REQ-022 HEX_MODE=1: after every LINE_BYTES bytes, and after the final byte if the line is partial, SHALL send 8'h0D then 8'h0A.
REQ-023 DRAIN: once FIFO is empty, formatter is idle and uart_ready=1, SHALL pulse done for one cycle, deassert busy and return to IDLE.
REQ-024 Flash reads and UART transmission SHALL overlap; UART stall SHALL only delay WAIT_ROOM and never lose or reorder bytes.

Reset
REQ-025 With rst=0 on a clk edge: state=IDLE, FIFO empty, formatter idle, line counter=0.
REQ-026 With rst=0 on a clk edge: busy=0, done=0, spi_go=0, uart_start=0, spi_addr=0, spi_len=0, uart_data=0.
REQ-027 Reset mid-dump SHALL abort immediately; no done pulse SHALL follow, and in-flight spi_valid data after reset SHALL be discarded.

Verification
REQ-028 Raw, NUM_BYTES=4, BURST=16, flash model returns 11,22,33,44 from 0x100000 -> one spi_go with spi_len=3; UART chars 11,22,33,44; one done pulse.
REQ-029 Raw, NUM_BYTES=40, BURST=16, FIFO_DEPTH=32, uart_ready held 0 for 2000 cycles -> spi_go count=2 before the stall ends, third burst (spi_len=7) issued only after drain; 40 bytes in order.
REQ-030 HEX_MODE=1, LINE_BYTES=2, bytes 0x0A,0xF3,0x5C -> chars "0A","F3",0D,0A,"5C",0D,0A.
REQ-031 START_ADDR=24'hFFFFFE, NUM_BYTES=4, BURST=4 -> spi_addr=FFFFFE, bytes read from FFFFFE,FFFFFF,000000,000001 in order.
REQ-032 rst pulsed low during the second burst -> all outputs at reset values next cycle; following start gives a clean full dump with exactly one done.
REQ-033 start pulsed while busy -> ignored, exactly NUM_BYTES bytes and one done.
